// File: rtl/alu_share_ctrl_pkg.sv
// Shared types and constants for the shared add/sub controller.
// Operand/result widths, op codes and FSM state encoding.
package alu_share_ctrl_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int OPND_W    = 3;
    localparam int RES_W     = 4;
    localparam int OPND_SIGN = OPND_W - 1;
    localparam int RES_SIGN  = RES_W - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Request, datapath and response signals of the shared add/sub controller.
// slave = controller view, master = surrounding environment view.
interface alu_share_ctrl_if;
    import alu_share_ctrl_pkg::*;

    logic              req0_valid;
    logic              req0_ready;
    logic              req0_op;
    logic [OPND_W-1:0] req0_a;
    logic [OPND_W-1:0] req0_b;

    logic              req1_valid;
    logic              req1_ready;
    logic              req1_op;
    logic [OPND_W-1:0] req1_a;
    logic [OPND_W-1:0] req1_b;

    logic              alu_op;
    logic [OPND_W-1:0] alu_a;
    logic [OPND_W-1:0] alu_b;
    logic [RES_W-1:0]  alu_r;
    logic              alu_sf;
    logic              alu_zf;
    logic              alu_dzf;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [RES_W-1:0]  rsp_r;
    logic              rsp_sf;
    logic              rsp_zf;
    logic              rsp_dzf;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req0_ready, req1_ready,
        output alu_op, alu_a, alu_b,
        input  alu_r, alu_sf, alu_zf, alu_dzf,
        output rsp_valid, rsp_id, rsp_r, rsp_sf, rsp_zf, rsp_dzf,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req0_ready, req1_ready,
        input  alu_op, alu_a, alu_b,
        output alu_r, alu_sf, alu_zf, alu_dzf,
        input  rsp_valid, rsp_id, rsp_r, rsp_sf, rsp_zf, rsp_dzf,
        output rsp_ready
    );

endinterface

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, tie goes to the requester
// not served last; the pointer moves only when a grant is taken.
module rr_arb2 #(
    parameter int unsigned FIRST_PRI = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last;

    always_comb begin
        grant = '0;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = '0;
        endcase
    end

    // Reset value makes FIRST_PRI look like the "other" requester was served last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last <= 1'(FIRST_PRI == 0);
        else if (advance && grant != '0)
            last <= grant[1];
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Time-shares one external add/sub datapath between two requesters:
// arbitrate, drive and hold operands, capture result, return it to the winner.
module alu_share_ctrl
    import alu_share_ctrl_pkg::*;
#(
    parameter int unsigned ISSUE_WAIT = 1,
    parameter int unsigned FIRST_PRI  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_share_ctrl_if.slave  bus
);

    localparam logic [2:0] WAIT_INIT = 3'(ISSUE_WAIT - 1);

    state_t     state;
    state_t     state_nx;
    logic [2:0] cnt;
    logic [1:0] grant;
    logic       take;

    rr_arb2 #(.FIRST_PRI(FIRST_PRI)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid   ({bus.req1_valid, bus.req0_valid}),
        .advance (take),
        .grant   (grant)
    );

    always_comb begin
        state_nx       = state;
        take           = 1'b0;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        case (state)
            IDLE: begin
                bus.req0_ready = grant[0];
                bus.req1_ready = grant[1];
                if (grant != '0) begin
                    take     = 1'b1;
                    state_nx = ISSUE;
                end
            end
            ISSUE:   if (cnt == '0) state_nx = RESP;
            RESP:    if (bus.rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            bus.alu_op    <= 1'b0;
            bus.alu_a     <= '0;
            bus.alu_b     <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= 1'b0;
            bus.rsp_r     <= '0;
            bus.rsp_sf    <= 1'b0;
            bus.rsp_zf    <= 1'b0;
            bus.rsp_dzf   <= 1'b0;
        end else if (take) begin
            bus.alu_op <= grant[1] ? bus.req1_op : bus.req0_op;
            bus.alu_a  <= grant[1] ? bus.req1_a  : bus.req0_a;
            bus.alu_b  <= grant[1] ? bus.req1_b  : bus.req0_b;
            bus.rsp_id <= grant[1];
            cnt        <= WAIT_INIT;
        end else if (state == ISSUE) begin
            if (cnt != '0) begin
                cnt <= cnt - 3'd1;
            end else begin
                bus.rsp_r     <= bus.alu_r;
                bus.rsp_sf    <= bus.alu_sf;
                bus.rsp_zf    <= bus.alu_zf;
                bus.rsp_dzf   <= bus.alu_dzf;
                bus.rsp_valid <= 1'b1;
            end
        end else if (state == RESP && bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench: two controllers (ISSUE_WAIT 1/FIRST_PRI 0 and
// ISSUE_WAIT 3/FIRST_PRI 1) against a transaction-level reference model.
module tb_alu_share_ctrl;

    localparam int IW0 = 1;
    localparam int IW1 = 3;
    localparam int FP0 = 0;
    localparam int FP1 = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [1:0] i_valid [2];
    logic [6:0] i_cmd   [2][2];   // {op, a, b}
    logic       i_rr    [2];
    logic       dp_force[2];
    logic [6:0] dp_frc  [2];      // {r, sf, zf, dzf}

    logic [1:0] o_ready [2];
    logic       o_rv    [2];
    logic [7:0] o_rsp   [2];      // {id, r, sf, zf, dzf}
    logic [6:0] o_alu   [2];      // {op, a, b}

    alu_share_ctrl_if if0();
    alu_share_ctrl_if if1();

    alu_share_ctrl #(.ISSUE_WAIT(IW0), .FIRST_PRI(FP0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0));
    alu_share_ctrl #(.ISSUE_WAIT(IW1), .FIRST_PRI(FP1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1));

    // Behavioural sign-magnitude add/sub: {r, sf, zf, dzf}
    function automatic logic [6:0] dp_calc(input logic [6:0] cmd);
        int va, vb, r;
        logic [3:0] rr;
        va = cmd[5] ? -int'(cmd[4:3]) : int'(cmd[4:3]);
        vb = cmd[2] ? -int'(cmd[1:0]) : int'(cmd[1:0]);
        r  = cmd[6] ? va - vb : va + vb;
        rr = (r < 0) ? {1'b1, 3'(-r)} : {1'b0, 3'(r)};
        return {rr, rr[3], rr[2:0] == 3'b000, 1'b0};
    endfunction

    logic [6:0] dp0, dp1;
    assign dp0 = dp_force[0] ? dp_frc[0] : dp_calc({if0.alu_op, if0.alu_a, if0.alu_b});
    assign dp1 = dp_force[1] ? dp_frc[1] : dp_calc({if1.alu_op, if1.alu_a, if1.alu_b});

    assign if0.req0_valid = i_valid[0][0];
    assign if0.req1_valid = i_valid[0][1];
    assign {if0.req0_op, if0.req0_a, if0.req0_b} = i_cmd[0][0];
    assign {if0.req1_op, if0.req1_a, if0.req1_b} = i_cmd[0][1];
    assign if0.rsp_ready = i_rr[0];
    assign {if0.alu_r, if0.alu_sf, if0.alu_zf, if0.alu_dzf} = dp0;
    assign o_ready[0] = {if0.req1_ready, if0.req0_ready};
    assign o_rv[0]    = if0.rsp_valid;
    assign o_rsp[0]   = {if0.rsp_id, if0.rsp_r, if0.rsp_sf, if0.rsp_zf, if0.rsp_dzf};
    assign o_alu[0]   = {if0.alu_op, if0.alu_a, if0.alu_b};

    assign if1.req0_valid = i_valid[1][0];
    assign if1.req1_valid = i_valid[1][1];
    assign {if1.req0_op, if1.req0_a, if1.req0_b} = i_cmd[1][0];
    assign {if1.req1_op, if1.req1_a, if1.req1_b} = i_cmd[1][1];
    assign if1.rsp_ready = i_rr[1];
    assign {if1.alu_r, if1.alu_sf, if1.alu_zf, if1.alu_dzf} = dp1;
    assign o_ready[1] = {if1.req1_ready, if1.req0_ready};
    assign o_rv[1]    = if1.rsp_valid;
    assign o_rsp[1]   = {if1.rsp_id, if1.rsp_r, if1.rsp_sf, if1.rsp_zf, if1.rsp_dzf};
    assign o_alu[1]   = {if1.alu_op, if1.alu_a, if1.alu_b};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase 0 = free, 1 = operands settling, 2 = response pending
    int         phase  [2] = '{0, 0};
    int         left   [2] = '{0, 0};
    logic       prio   [2];
    logic [7:0] exp_rsp[2];
    logic [6:0] exp_alu[2];

    always @(negedge clk) begin : mon
        int w;
        logic [1:0] er;
        logic [6:0] res;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                check($sformatf("d%0d_rst_ready", d), o_ready[d], 2'b00);
                check($sformatf("d%0d_rst_rv", d), o_rv[d], 1'b0);
                check($sformatf("d%0d_rst_rsp", d), o_rsp[d], 8'h00);
                check($sformatf("d%0d_rst_alu", d), o_alu[d], 7'h00);
                phase[d]   = 0;
                prio[d]    = 1'((d == 0) ? FP0 : FP1);
                exp_alu[d] = '0;
                exp_rsp[d] = '0;
            end else begin
                w = -1;
                if (phase[d] == 0) begin
                    if (i_valid[d] == 2'b11) w = int'(prio[d]);
                    else if (i_valid[d][0])  w = 0;
                    else if (i_valid[d][1])  w = 1;
                end
                er = (w < 0) ? 2'b00 : ((w == 0) ? 2'b01 : 2'b10);
                check($sformatf("d%0d_ready", d), o_ready[d], er);
                check($sformatf("d%0d_rv", d), o_rv[d], phase[d] == 2);
                if (phase[d] == 2)
                    check($sformatf("d%0d_rsp", d), o_rsp[d], exp_rsp[d]);
                check($sformatf("d%0d_alu", d), o_alu[d], exp_alu[d]);
                if (w >= 0) begin
                    exp_alu[d] = i_cmd[d][w];
                    res        = dp_force[d] ? dp_frc[d] : dp_calc(i_cmd[d][w]);
                    exp_rsp[d] = {1'(w), res};
                    left[d]    = (d == 0) ? IW0 : IW1;
                    phase[d]   = 1;
                    prio[d]    = (w == 0);
                end else if (phase[d] == 1) begin
                    left[d]--;
                    if (left[d] == 0) phase[d] = 2;
                end else if (phase[d] == 2 && i_rr[d]) begin
                    phase[d] = 0;
                end
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Present a request and return just after the edge that accepts it.
    task automatic do_req(input int d, input int who, input logic [6:0] cmd);
        bit ok;
        i_cmd[d][who]   = cmd;
        i_valid[d][who] = 1'b1;
        ok = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (o_ready[d][who]) begin
                ok = 1;
                break;
            end
        end
        check($sformatf("d%0d_req_accept", d), ok, 1'b1);
        sync();
        i_valid[d][who] = 1'b0;
    endtask

    task automatic wait_rsp(input int d);
        bit ok;
        ok = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (o_rv[d]) begin
                ok = 1;
                break;
            end
        end
        check($sformatf("d%0d_rsp_seen", d), ok, 1'b1);
    endtask

    initial begin : stim
        logic [14:0] snap;
        bit ok;
        for (int d = 0; d < 2; d++) begin
            i_valid[d] = '0;
            i_cmd[d][0] = '0;
            i_cmd[d][1] = '0;
            i_rr[d] = 1'b1;
            dp_force[d] = 1'b0;
            dp_frc[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        sync();

        // T1: +2 + -3 = -1
        do_req(0, 0, {1'b0, 3'b010, 3'b111});
        check("t1_alu", o_alu[0], {1'b0, 3'b010, 3'b111});
        check("t1_rv_e0", o_rv[0], 1'b0);
        sync();
        check("t1_rv", o_rv[0], 1'b1);
        check("t1_id", if0.rsp_id, 1'b0);
        check("t1_r", if0.rsp_r, 4'b1001);
        check("t1_sf", if0.rsp_sf, 1'b1);
        check("t1_zf", if0.rsp_zf, 1'b0);

        // T2: 3 - 3 = 0 from requester 1
        do_req(0, 1, {1'b1, 3'b011, 3'b011});
        sync();
        check("t2_rv", o_rv[0], 1'b1);
        check("t2_rsp", o_rsp[0], {1'b1, 4'b0000, 1'b0, 1'b1, 1'b0});

        // T3: both valid continuously, grants alternate starting with 0
        sync();
        i_cmd[0][0] = {1'b0, 3'b001, 3'b001};
        i_cmd[0][1] = {1'b1, 3'b110, 3'b001};
        i_valid[0]  = 2'b11;
        for (int k = 0; k < 4; k++) begin
            ok = 0;
            for (int n = 0; n < 20; n++) begin
                @(negedge clk);
                if (o_ready[0] != 2'b00) begin
                    ok = 1;
                    break;
                end
            end
            check("t3_grant", o_ready[0], (k % 2 == 0) ? 2'b01 : 2'b10);
            sync();
        end
        i_valid[0] = 2'b00;
        repeat (4) sync();

        // T4: response back-pressure with a competing request waiting
        i_rr[0] = 1'b0;
        do_req(0, 0, {1'b0, 3'b101, 3'b011});
        i_cmd[0][1]   = {1'b0, 3'b011, 3'b010};
        i_valid[0][1] = 1'b1;
        wait_rsp(0);
        snap = {o_rsp[0], o_alu[0]};
        repeat (5) begin
            @(negedge clk);
            check("t4_hold", {o_rsp[0], o_alu[0]}, snap);
            check("t4_rv", o_rv[0], 1'b1);
            check("t4_ready", o_ready[0], 2'b00);
        end
        sync();
        i_rr[0] = 1'b1;
        @(negedge clk);
        check("t4_rv_last", o_rv[0], 1'b1);
        @(negedge clk);
        check("t4_idle_ready", o_ready[0], 2'b10);
        sync();
        i_valid[0][1] = 1'b0;
        repeat (4) sync();

        // Flags and negative zero from the datapath are forwarded untouched
        dp_frc[0]   = {4'b1000, 1'b1, 1'b1, 1'b1};
        dp_force[0] = 1'b1;
        do_req(0, 1, {1'b0, 3'b000, 3'b000});
        wait_rsp(0);
        check("fwd_rsp", o_rsp[0], {1'b1, 4'b1000, 1'b1, 1'b1, 1'b1});
        sync();
        dp_force[0] = 1'b0;
        repeat (2) sync();

        // T5: ISSUE_WAIT = 3 latency, 3 + 3 = 6
        do_req(1, 0, {1'b0, 3'b011, 3'b011});
        check("t5_rv_e0", o_rv[1], 1'b0);
        sync();
        check("t5_rv_e1", o_rv[1], 1'b0);
        sync();
        check("t5_rv_e2", o_rv[1], 1'b0);
        sync();
        check("t5_rv_e3", o_rv[1], 1'b1);
        check("t5_r", if1.rsp_r, 4'b0110);
        repeat (3) sync();

        // T6: reset while DUT0 holds a response and DUT1 is settling operands
        i_rr[0] = 1'b0;
        do_req(0, 0, {1'b1, 3'b001, 3'b110});
        wait_rsp(0);
        sync();
        do_req(1, 1, {1'b1, 3'b011, 3'b001});
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("t6_d%0d_rv", d), o_rv[d], 1'b0);
            check($sformatf("t6_d%0d_rsp", d), o_rsp[d], 8'h00);
            check($sformatf("t6_d%0d_alu", d), o_alu[d], 7'h00);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        i_rr[0] = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("t6_no_rsp0", o_rv[0], 1'b0);
            check("t6_no_rsp1", o_rv[1], 1'b0);
        end
        sync();
        i_valid[0] = 2'b11;
        i_valid[1] = 2'b11;
        @(negedge clk);
        check("t6_tie0", o_ready[0], 2'b01);
        check("t6_tie1", o_ready[1], 2'b10);
        sync();
        i_valid[0] = 2'b00;
        i_valid[1] = 2'b00;
        repeat (6) sync();

        // Random traffic on both controllers, checked by the model every cycle
        repeat (3000) begin
            sync();
            for (int d = 0; d < 2; d++) begin
                i_valid[d]  = 2'($urandom);
                i_cmd[d][0] = 7'($urandom);
                i_cmd[d][1] = 7'($urandom);
                i_rr[d]     = ($urandom_range(0, 9) < 7);
            end
        end
        sync();
        for (int d = 0; d < 2; d++) begin
            i_valid[d] = 2'b00;
            i_rr[d]    = 1'b1;
        end
        repeat (10) sync();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Two-requester controller that time-shares one sign-magnitude add/sub datapath (3-bit operands, 4-bit result, SF/ZF/DZF flags).
- Arbitrates round-robin, registers the winning operation onto the datapath inputs and holds them for a settle window.
- Captures result and flags, then returns them to the winner over a valid/ready response channel.
- Sits between the front-end command sources and the combinational add/sub datapath, which is instantiated outside this block.

Parameters:
- ISSUE_WAIT, 1, cycles the datapath inputs are held before capture; legal range 1..7.
- FIRST_PRI, 0, requester that wins the first contended arbitration after reset (0 or 1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid / req1_valid  in  1  requester 0/1 has an operation.
- req0_ready / req1_ready  out  1  requester 0/1 operation accepted this cycle.
- req0_op / req1_op  in  1  0 = A+B, 1 = A-B.
- req0_a, req0_b / req1_a, req1_b  in  3  sign-magnitude operands; bit2 = sign, bits1:0 = magnitude.
- alu_op  out  1  registered op to datapath.
- alu_a, alu_b  out  3  registered operands to datapath.
- alu_r  in  4  datapath result; bit3 = sign, bits2:0 = magnitude.
- alu_sf, alu_zf, alu_dzf  in  1  datapath flags.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  1  requester index the response belongs to.
- rsp_r  out  4  captured result.
- rsp_sf, rsp_zf, rsp_dzf  out  1  captured flags.

Behaviour:
- Reset (async, rst_n low): state = IDLE; all outputs 0 (ready, rsp_valid, rsp_id, rsp_r, flags, alu_op/a/b); wait counter = 0; RR pointer set so FIRST_PRI wins the next tie.
- Reset mid-ISSUE or mid-RESP: the transaction is dropped and no response is produced. rsp_valid falls asynchronously.
- FSM IDLE:
  - reqN_ready = 1 only for the granted requester.
  - Grant: the sole valid requester; if both are valid, the one not served last.
  - The valid-to-ready combinational path is permitted.
  - On handshake edge E0: latch op/a/b into alu_* and the winner index into rsp_id; update the RR pointer to the winner; counter = ISSUE_WAIT-1; go to ISSUE.
- FSM ISSUE:
  - Both readies are 0; alu_* are held stable.
  - Counter decrements each cycle.
  - On the edge where the counter is 0: capture alu_r/sf/zf/dzf into rsp_*; rsp_valid = 1; go to RESP.
  - Latency: rsp_valid is high from edge E0+ISSUE_WAIT.
- FSM RESP:
  - rsp_* and alu_* are held stable while rsp_valid && !rsp_ready.
  - On the rsp_valid && rsp_ready edge: rsp_valid = 0; go to IDLE.
  - A new request cannot be accepted until the cycle after (throughput: 1 operation per ISSUE_WAIT+2 cycles minimum).
- Request inputs are sampled only on the handshake edge. Changes while waiting are legal and take effect if still presented at grant.
- Datapath outputs pass through unmodified:
  - no re-encoding of negative zero;
  - DZF is forwarded as-is (the add/sub path drives 0; the port exists for future shared ops).
- Arithmetic is done only by the datapath. Expected results span -6..+6 in 4-bit sign-magnitude.
- A requester that deasserts valid before being granted loses nothing. The RR pointer changes only on a grant.

Decomposition:
- Shared package holds:
  - OP_ADD = 1'b0, OP_SUB = 1'b1;
  - OPND_W = 3, RES_W = 4;
  - state encodings IDLE / ISSUE / RESP;
  - sign-bit index constants.
- One sub-module, rr_arb2: 2-way round-robin arbiter (valid[1:0], advance, FIRST_PRI → one-hot grant).
- FSM, counter and capture registers stay in alu_share_ctrl.

Test Plan:
1. Reset, then req0 only: op=0, a=3'b010 (+2), b=3'b111 (-3), rsp_ready=1, ISSUE_WAIT=1 → alu_a=010 and alu_b=111 after E0; rsp_valid at E0+1 with rsp_id=0, rsp_r=4'b1001 (-1), sf=1, zf=0.
2. req1: op=1, a=3'b011, b=3'b011 → rsp_r=4'b0000, zf=1, sf=0, rsp_id=1.
3. Both valid continuously, 4 operations (FIRST_PRI=0) → grants 0,1,0,1. The non-granted ready stays 0; each rsp_id matches.
4. rsp_ready held 0 for 5 cycles → rsp_valid and rsp_* stable; both req_ready = 0; state returns to IDLE one cycle after rsp_ready rises.
5. ISSUE_WAIT=3, op=0, a=3'b011, b=3'b011 → rsp_valid first seen at E0+3, rsp_r=4'b0110 (+6).
6. rst_n pulsed low during ISSUE → all outputs 0 immediately; no response after release; the next tie is granted to FIRST_PRI.
